// File: rtl/sdram_cmd_arbiter.sv
// sdram_cmd_arbiter
// Shares the SDRAM pins between a read engine and a write engine, and
// interleaves periodic PRECHARGE-ALL / AUTO REFRESH sequences.
//
// Parameters
//   REFRESH_INTERVAL  clocks between auto-refresh requests
//   T_RP              NOP clocks after PRECHARGE-ALL
//   T_RFC             NOP clocks after AUTO REFRESH
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   init_done                     SDRAM power-up done; arbiter is inert while low
//   rd_req / wr_req               application wants the read / write engine run
//   rd_enable / wr_enable         enable to the read / write engine
//   rd_idle / wr_idle             engine idle flags
//   rd_/wr_command,address,bank   engine-side SDRAM buses
//   auto_refresh                  refresh pending, broadcast to both engines
//   sdram_command,address,bank    registered bus to the SDRAM pins
//   missed_refresh                saturating count of intervals that expired
//                                 while a refresh was already pending
module sdram_cmd_arbiter #(
  parameter logic [15:0] REFRESH_INTERVAL = 16'd1560,
  parameter logic [3:0]  T_RP             = 4'd2,
  parameter logic [3:0]  T_RFC            = 4'd7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done,
  input  logic        rd_req,
  input  logic        wr_req,
  output logic        rd_enable,
  output logic        wr_enable,
  input  logic        rd_idle,
  input  logic        wr_idle,
  input  logic [2:0]  rd_command,
  input  logic [11:0] rd_address,
  input  logic [1:0]  rd_bank,
  input  logic [2:0]  wr_command,
  input  logic [11:0] wr_address,
  input  logic [1:0]  wr_bank,
  output logic        auto_refresh,
  output logic [2:0]  sdram_command,
  output logic [11:0] sdram_address,
  output logic [1:0]  sdram_bank,
  output logic [7:0]  missed_refresh
);

  // {RAS_n, CAS_n, WE_n} encodings, identical to the sdram_include.v defines
  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_AR  = 3'b001;

  typedef enum logic [2:0] {
    IDLE, GRANT_RD, GRANT_WR, DRAIN, PRECHARGE_ALL, REFRESH
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic        last_grant_rd, last_grant_rd_nxt;
  logic [15:0] timer;
  logic        refresh_pending;
  logic        clear_pending;
  logic [2:0]  cmd_nxt;
  logic [11:0] addr_nxt;
  logic [1:0]  bank_nxt;

  assign auto_refresh = refresh_pending;

  // Next-state and next pin values. In GRANT_x and DRAIN the pins follow the
  // engine recorded in last_grant_rd; everywhere else the arbiter drives its
  // own command with a zero address and bank unless stated otherwise.
  // wait_cnt counts the clocks spent in PRECHARGE_ALL / REFRESH: count 0 is
  // the command clock, the following T_RP / T_RFC clocks are NOPs.
  always_comb begin
    state_nxt         = state;
    wait_cnt_nxt      = wait_cnt;
    last_grant_rd_nxt = last_grant_rd;
    clear_pending     = 1'b0;
    cmd_nxt           = CMD_NOP;
    addr_nxt          = 12'h000;
    bank_nxt          = 2'b00;
    case (state)
      IDLE: begin
        if (init_done) begin
          if (refresh_pending) begin
            state_nxt    = PRECHARGE_ALL;
            wait_cnt_nxt = 4'd0;
          end else if (rd_req && wr_req) begin
            // round-robin: serve whichever engine did not go last
            state_nxt         = last_grant_rd ? GRANT_WR : GRANT_RD;
            last_grant_rd_nxt = ~last_grant_rd;
          end else if (rd_req) begin
            state_nxt         = GRANT_RD;
            last_grant_rd_nxt = 1'b1;
          end else if (wr_req) begin
            state_nxt         = GRANT_WR;
            last_grant_rd_nxt = 1'b0;
          end
        end
      end
      GRANT_RD: begin
        cmd_nxt  = rd_command;
        addr_nxt = rd_address;
        bank_nxt = rd_bank;
        if (!rd_req || refresh_pending) state_nxt = DRAIN;
      end
      GRANT_WR: begin
        cmd_nxt  = wr_command;
        addr_nxt = wr_address;
        bank_nxt = wr_bank;
        if (!wr_req || refresh_pending) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (last_grant_rd) begin
          cmd_nxt  = rd_command;
          addr_nxt = rd_address;
          bank_nxt = rd_bank;
          if (rd_idle) state_nxt = IDLE;
        end else begin
          cmd_nxt  = wr_command;
          addr_nxt = wr_address;
          bank_nxt = wr_bank;
          if (wr_idle) state_nxt = IDLE;
        end
      end
      PRECHARGE_ALL: begin
        if (wait_cnt == 4'd0) begin
          cmd_nxt  = CMD_PRE;
          addr_nxt = 12'h400;
        end
        if (wait_cnt == T_RP) begin
          state_nxt    = REFRESH;
          wait_cnt_nxt = 4'd0;
        end else begin
          wait_cnt_nxt = wait_cnt + 4'd1;
        end
      end
      REFRESH: begin
        if (wait_cnt == 4'd0) begin
          cmd_nxt       = CMD_AR;
          clear_pending = 1'b1;
        end
        if (wait_cnt == T_RFC) begin
          state_nxt    = IDLE;
          wait_cnt_nxt = 4'd0;
        end else begin
          wait_cnt_nxt = wait_cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus the registered pin bus and engine enables. The
  // enables follow the next state so a grant is visible on the same edge
  // that moves the FSM into GRANT_x, and both can never be high together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= 4'd0;
      last_grant_rd <= 1'b0;
      rd_enable     <= 1'b0;
      wr_enable     <= 1'b0;
      sdram_command <= CMD_NOP;
      sdram_address <= 12'h000;
      sdram_bank    <= 2'b00;
    end else begin
      state         <= state_nxt;
      wait_cnt      <= wait_cnt_nxt;
      last_grant_rd <= last_grant_rd_nxt;
      rd_enable     <= (state_nxt == GRANT_RD);
      wr_enable     <= (state_nxt == GRANT_WR);
      sdram_command <= cmd_nxt;
      sdram_address <= addr_nxt;
      sdram_bank    <= bank_nxt;
    end
  end

  // Refresh timer. An expiry always (re)asserts refresh_pending, even on the
  // AR clock, so no refresh is lost. An expiry only counts as missed when
  // the pending refresh is not being serviced on that same clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer           <= REFRESH_INTERVAL - 16'd1;
      refresh_pending <= 1'b0;
      missed_refresh  <= 8'd0;
    end else if (!init_done) begin
      timer <= REFRESH_INTERVAL - 16'd1;
      if (clear_pending) refresh_pending <= 1'b0;
    end else if (timer == 16'd0) begin
      timer           <= REFRESH_INTERVAL - 16'd1;
      refresh_pending <= 1'b1;
      if (refresh_pending && !clear_pending && missed_refresh != 8'hFF)
        missed_refresh <= missed_refresh + 8'd1;
    end else begin
      timer <= timer - 16'd1;
      if (clear_pending) refresh_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// tb_sdram_cmd_arbiter
// Drives directed scenarios followed by random traffic into
// sdram_cmd_arbiter and compares every output on every clock against a
// transaction-level model: the refresh timer is modelled as a count of
// enabled clocks, a refresh is a scripted queue of pin values, and a grant
// is tracked as "which engine holds the bus / is it releasing".
module tb_sdram_cmd_arbiter;

  localparam logic [15:0] RI   = 16'd40;
  localparam logic [3:0]  TRP  = 4'd2;
  localparam logic [3:0]  TRFC = 4'd7;
  localparam logic [2:0]  CMD_NOP = 3'b111;
  localparam logic [2:0]  CMD_PRE = 3'b010;
  localparam logic [2:0]  CMD_AR  = 3'b001;

  logic        clk = 1'b0;
  logic        rst, init_done, rd_req, wr_req, rd_idle, wr_idle;
  logic [2:0]  rd_command, wr_command;
  logic [11:0] rd_address, wr_address;
  logic [1:0]  rd_bank, wr_bank;
  logic        rd_enable, wr_enable, auto_refresh;
  logic [2:0]  sdram_command;
  logic [11:0] sdram_address;
  logic [1:0]  sdram_bank;
  logic [7:0]  missed_refresh;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  // reference model state
  int          m_run;
  bit          m_pending;
  int          m_missed;
  int          m_holder;
  bit          m_releasing;
  bit          m_last_rd;
  logic [2:0]  q_cmd[$];
  logic [11:0] q_addr[$];
  logic [2:0]  e_cmd;
  logic [11:0] e_addr;
  logic [1:0]  e_bank;

  sdram_cmd_arbiter #(
    .REFRESH_INTERVAL(RI),
    .T_RP(TRP),
    .T_RFC(TRFC)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .rd_req(rd_req), .wr_req(wr_req),
    .rd_enable(rd_enable), .wr_enable(wr_enable),
    .rd_idle(rd_idle), .wr_idle(wr_idle),
    .rd_command(rd_command), .rd_address(rd_address), .rd_bank(rd_bank),
    .wr_command(wr_command), .wr_address(wr_address), .wr_bank(wr_bank),
    .auto_refresh(auto_refresh),
    .sdram_command(sdram_command), .sdram_address(sdram_address),
    .sdram_bank(sdram_bank), .missed_refresh(missed_refresh)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_run = 0; m_pending = 1'b0; m_missed = 0;
    m_holder = 0; m_releasing = 1'b0; m_last_rd = 1'b0;
    q_cmd.delete(); q_addr.delete();
    e_cmd = CMD_NOP; e_addr = 12'h000; e_bank = 2'b00;
  endtask

  // One rising edge of the reference, using the inputs the DUT sampled.
  task automatic model_edge();
    bit clearing = 1'b0;
    bit expire   = 1'b0;
    bit h_req, h_idle;
    if (rst) begin
      model_reset();
      return;
    end
    if (q_cmd.size() > 0) begin
      e_cmd  = q_cmd.pop_front();
      e_addr = q_addr.pop_front();
      e_bank = 2'b00;
      if (e_cmd == CMD_AR) clearing = 1'b1;
    end else if (m_holder != 0) begin
      if (m_holder == 1) begin
        e_cmd = rd_command; e_addr = rd_address; e_bank = rd_bank;
        h_req = rd_req; h_idle = rd_idle;
      end else begin
        e_cmd = wr_command; e_addr = wr_address; e_bank = wr_bank;
        h_req = wr_req; h_idle = wr_idle;
      end
      if (m_releasing) begin
        if (h_idle) begin
          m_holder = 0;
          m_releasing = 1'b0;
        end
      end else if (!h_req || m_pending) begin
        m_releasing = 1'b1;
      end
    end else begin
      e_cmd = CMD_NOP; e_addr = 12'h000; e_bank = 2'b00;
      if (init_done) begin
        if (m_pending) begin
          q_cmd.push_back(CMD_PRE); q_addr.push_back(12'h400);
          for (int i = 0; i < int'(TRP); i++) begin
            q_cmd.push_back(CMD_NOP); q_addr.push_back(12'h000);
          end
          q_cmd.push_back(CMD_AR); q_addr.push_back(12'h000);
          for (int i = 0; i < int'(TRFC); i++) begin
            q_cmd.push_back(CMD_NOP); q_addr.push_back(12'h000);
          end
        end else if (rd_req && wr_req) begin
          m_holder = m_last_rd ? 2 : 1;
        end else if (rd_req) begin
          m_holder = 1;
        end else if (wr_req) begin
          m_holder = 2;
        end
        if (m_holder != 0) m_last_rd = (m_holder == 1);
      end
    end
    if (!init_done) begin
      m_run = 0;
    end else begin
      m_run++;
      expire = ((m_run % int'(RI)) == 0);
    end
    if (expire) begin
      if (m_pending && !clearing && m_missed < 255) m_missed++;
      m_pending = 1'b1;
    end else if (clearing) begin
      m_pending = 1'b0;
    end
  endtask

  task automatic check_output();
    logic       x_rd, x_wr;
    logic [7:0] x_missed;
    x_rd     = (m_holder == 1) && !m_releasing;
    x_wr     = (m_holder == 2) && !m_releasing;
    x_missed = 8'(m_missed);
    checks++;
    assert (rd_enable === x_rd) else begin
      failures++;
      $error("[TB] FAIL rd_enable cycle=%0d observed=%b expected=%b", cycle, rd_enable, x_rd);
    end
    checks++;
    assert (wr_enable === x_wr) else begin
      failures++;
      $error("[TB] FAIL wr_enable cycle=%0d observed=%b expected=%b", cycle, wr_enable, x_wr);
    end
    checks++;
    assert (auto_refresh === m_pending) else begin
      failures++;
      $error("[TB] FAIL auto_refresh cycle=%0d observed=%b expected=%b", cycle, auto_refresh, m_pending);
    end
    checks++;
    assert (sdram_command === e_cmd) else begin
      failures++;
      $error("[TB] FAIL sdram_command cycle=%0d observed=%b expected=%b", cycle, sdram_command, e_cmd);
    end
    checks++;
    assert (sdram_address === e_addr) else begin
      failures++;
      $error("[TB] FAIL sdram_address cycle=%0d observed=%h expected=%h", cycle, sdram_address, e_addr);
    end
    checks++;
    assert (sdram_bank === e_bank) else begin
      failures++;
      $error("[TB] FAIL sdram_bank cycle=%0d observed=%0d expected=%0d", cycle, sdram_bank, e_bank);
    end
    checks++;
    assert (missed_refresh === x_missed) else begin
      failures++;
      $error("[TB] FAIL missed_refresh cycle=%0d observed=%0d expected=%0d", cycle, missed_refresh, x_missed);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic init, input logic rr,
                                input logic wr, input logic ri, input logic wi);
    rst = r; init_done = init; rd_req = rr; wr_req = wr; rd_idle = ri; wr_idle = wi;
  endtask

  // One clock: fresh random engine buses, edge, model update, check.
  task automatic step();
    rd_command = 3'($urandom); rd_address = 12'($urandom); rd_bank = 2'($urandom);
    wr_command = 3'($urandom); wr_address = 12'($urandom); wr_bank = 2'($urandom);
    @(posedge clk);
    model_edge();
    cycle++;
    #1;
    check_output();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bit found;
    model_reset();
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run(2);
    checks++;
    assert (sdram_command === CMD_NOP && missed_refresh === 8'd0) else begin
      failures++;
      $error("[TB] FAIL reset_bus observed=%b/%0d expected=%b/0", sdram_command, missed_refresh, CMD_NOP);
    end

    $display("[TB] inert while init_done low");
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    run(5000);

    $display("[TB] periodic refresh with no requests");
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    run(3 * int'(RI));

    $display("[TB] round-robin with both requests held");
    for (int k = 0; k < 12; k++) begin
      apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      run(5);
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      run(1);
    end

    $display("[TB] read held across refresh with slow drain");
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    run(int'(RI) + 50);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    run(2 * int'(RI));

    $display("[TB] engine never idles -> missed refresh saturates");
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    run(300 * int'(RI));
    checks++;
    assert (missed_refresh === 8'hFF) else begin
      failures++;
      $error("[TB] FAIL missed_saturate observed=%0d expected=255", missed_refresh);
    end
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    run(int'(RI));

    $display("[TB] reset during refresh NOP wait");
    found = 1'b0;
    for (int i = 0; i < 3 * int'(RI) && !found; i++) begin
      step();
      if (q_cmd.size() == 3) found = 1'b1;
    end
    checks++;
    assert (found === 1'b1) else begin
      failures++;
      $error("[TB] FAIL refresh_wait_timeout observed=%b expected=1", found);
    end
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    run(1);
    checks++;
    assert (auto_refresh === 1'b0 && sdram_command === CMD_NOP) else begin
      failures++;
      $error("[TB] FAIL reset_in_refresh observed=%b/%b expected=0/%b", auto_refresh, sdram_command, CMD_NOP);
    end
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    run(2 * int'(RI));

    $display("[TB] random traffic");
    for (int i = 0; i < 4000; i++) begin
      apply_stimulus($urandom_range(0, 299) == 0, $urandom_range(0, 39) != 0,
                     $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                     $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
